// File: rtl/idli_sqi_resp.sv
// rtl/idli_sqi_resp.sv - SQI memory responder with an internal byte array
//
// Purpose : target end of the quad SQI link. Decodes READ (0x03) and
//           WRITE (0x02) nibble by nibble into a 2^ADDR_W byte array and
//           drives read data back on the SIO nibble.
// Ports   : i_clk        clock, one nibble per rising edge
//           i_rst        synchronous active-high reset
//           i_sqi_cs_n   chip select, active low
//           i_sqi_sio    nibble from initiator
//           o_sqi_sio    registered nibble to initiator
//           o_sqi_mode   SQI_MODE_OUT only while o_sqi_sio carries read data
// Option  : IDLI_SQI_RESP_MODE_REG_EN adds the mode register with WRMR (0x01),
//           RDMR (0x05) and byte/page/sequential addressing.

package idli_sqi_pkg;
   typedef enum logic {
      SQI_MODE_IN  = 1'b0,
      SQI_MODE_OUT = 1'b1
   } sqi_mode_t;
endpackage

module idli_sqi_resp
   import idli_sqi_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_sqi_cs_n,
   input  logic [3:0] i_sqi_sio,
   output logic [3:0] o_sqi_sio,
   output sqi_mode_t  o_sqi_mode
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_READ,
      ST_WRITE,
      ST_IGNORE,
      ST_WRMR,
      ST_RDMR
   } state_t;

   logic [7:0] mem [2**ADDR_W];

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [3:0]        hi_q, hi_d;       // cmd hi nibble / staged data hi nibble
   logic [ADDR_W-1:0] sh_q, sh_d;       // address shift register
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              lo_q, lo_d;       // next data nibble is the lo half
   logic              rd_q, rd_d;       // current transaction is a read
   logic [3:0]        sio_q, sio_d;
   sqi_mode_t         mode_q, mode_d;
   logic              mem_we;
   logic [ADDR_W-1:0] addr_inc;

`ifdef IDLI_SQI_RESP_MODE_REG_EN
   localparam logic [ADDR_W-1:0] PAGE_MASK = (ADDR_W >= 5) ? ADDR_W'(31) : '1;
   logic [1:0] mr_q, mr_d;              // mode[7:6]; lower bits are always 0

   always_comb begin
      case (mr_q)
         2'b00:   addr_inc = addr_q;
         2'b10:   addr_inc = (addr_q & ~PAGE_MASK) | ((addr_q + ADDR_W'(1)) & PAGE_MASK);
         default: addr_inc = addr_q + ADDR_W'(1);
      endcase
   end
`else
   assign addr_inc = addr_q + ADDR_W'(1);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      sh_d    = sh_q;
      addr_d  = addr_q;
      lo_d    = lo_q;
      rd_d    = rd_q;
      sio_d   = 4'h0;
      mode_d  = SQI_MODE_IN;
      mem_we  = 1'b0;
`ifdef IDLI_SQI_RESP_MODE_REG_EN
      mr_d    = mr_q;
`endif
      if (i_sqi_cs_n) begin
         // Abort at any nibble: a staged hi nibble is simply dropped.
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               hi_d    = i_sqi_sio;
               lo_d    = 1'b0;
               state_d = ST_CMD;
            end
            ST_CMD: begin
               cnt_d = 3'd0;
               case ({hi_q, i_sqi_sio})
                  8'h03: begin
                     rd_d    = 1'b1;
                     state_d = ST_ADDR;
                  end
                  8'h02: begin
                     rd_d    = 1'b0;
                     state_d = ST_ADDR;
                  end
`ifdef IDLI_SQI_RESP_MODE_REG_EN
                  8'h01: state_d = ST_WRMR;
                  8'h05: begin
                     sio_d   = {mr_q, 2'b00};
                     mode_d  = SQI_MODE_OUT;
                     state_d = ST_RDMR;
                  end
`endif
                  default: state_d = ST_IGNORE;
               endcase
            end
            ST_ADDR: begin
               // Only the low ADDR_W address bits survive the shift.
               sh_d  = ADDR_W'({sh_q, i_sqi_sio});
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd5) begin
                  addr_d  = ADDR_W'({sh_q, i_sqi_sio});
                  cnt_d   = 3'd0;
                  lo_d    = 1'b0;
                  state_d = rd_q ? ST_DUMMY : ST_WRITE;
               end
            end
            ST_DUMMY: begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd1) begin
                  sio_d   = mem[addr_q][7:4];
                  mode_d  = SQI_MODE_OUT;
                  lo_d    = 1'b1;
                  state_d = ST_READ;
               end
            end
            ST_READ: begin
               mode_d = SQI_MODE_OUT;
               if (lo_q) begin
                  sio_d = mem[addr_q][3:0];
                  lo_d  = 1'b0;
               end else begin
                  addr_d = addr_inc;
                  sio_d  = mem[addr_inc][7:4];
                  lo_d   = 1'b1;
               end
            end
            ST_WRITE: begin
               if (!lo_q) begin
                  hi_d = i_sqi_sio;
                  lo_d = 1'b1;
               end else begin
                  mem_we = 1'b1;
                  addr_d = addr_inc;
                  lo_d   = 1'b0;
               end
            end
`ifdef IDLI_SQI_RESP_MODE_REG_EN
            ST_WRMR: begin
               if (!lo_q) begin
                  hi_d = i_sqi_sio;
                  lo_d = 1'b1;
               end else begin
                  mr_d    = hi_q[3:2];
                  state_d = ST_IGNORE;
               end
            end
            ST_RDMR: begin
               // Lo nibble of the mode byte and all trailing nibbles are 0.
               mode_d = SQI_MODE_OUT;
            end
`endif
            ST_IGNORE: state_d = ST_IGNORE;
            default:   state_d = ST_IGNORE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         hi_q    <= 4'h0;
         sh_q    <= '0;
         addr_q  <= '0;
         lo_q    <= 1'b0;
         rd_q    <= 1'b0;
         sio_q   <= 4'h0;
         mode_q  <= SQI_MODE_IN;
`ifdef IDLI_SQI_RESP_MODE_REG_EN
         mr_q    <= 2'b01;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         sh_q    <= sh_d;
         addr_q  <= addr_d;
         lo_q    <= lo_d;
         rd_q    <= rd_d;
         sio_q   <= sio_d;
         mode_q  <= mode_d;
`ifdef IDLI_SQI_RESP_MODE_REG_EN
         mr_q    <= mr_d;
`endif
      end
   end

   // Array is not reset; reset only blocks a commit on the same edge.
   always_ff @(posedge i_clk) begin
      if (mem_we && !i_rst) begin
         mem[addr_q] <= {hi_q, i_sqi_sio};
      end
   end

   assign o_sqi_sio  = sio_q;
   assign o_sqi_mode = mode_q;

endmodule

// File: tb/tb_idli_sqi_resp.sv
// tb/tb_idli_sqi_resp.sv - directed scoreboard bench for idli_sqi_resp

module tb_idli_sqi_resp;
   import idli_sqi_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cs_n = 1'b1;
   logic [3:0] sio_in = 4'h0;
   logic [3:0] sio_out;
   sqi_mode_t  mode;

   int total = 0;
   int bad = 0;

   logic [7:0] model [256];
   logic [3:0] sbq [$];

   idli_sqi_resp #(.ADDR_W(8)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_sqi_cs_n (cs_n),
      .i_sqi_sio  (sio_in),
      .o_sqi_sio  (sio_out),
      .o_sqi_mode (mode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive on the falling edge, sample 1ns after the rising edge.
   task automatic tick(input logic cs, input logic [3:0] n);
      @(negedge clk);
      cs_n   = cs;
      sio_in = n;
      @(posedge clk);
      #1;
   endtask

   task automatic send_in(input string tag, input logic [3:0] n);
      tick(1'b0, n);
      chk(tag, 8'(mode), 8'(SQI_MODE_IN));
   endtask

   task automatic idle_chk(input string tag);
      tick(1'b1, 4'h0);
      chk({tag, "_mode"}, 8'(mode), 8'(SQI_MODE_IN));
      chk({tag, "_sio"}, 8'(sio_out), 8'h00);
   endtask

   task automatic hdr(input logic [7:0] cmd, input logic [23:0] a);
      send_in("cmd_mode", cmd[7:4]);
      send_in("cmd_mode", cmd[3:0]);
      for (int i = 5; i >= 0; i--) send_in("addr_mode", a[i*4 +: 4]);
   endtask

   task automatic wr(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1,
                     input int nb, input bit inc);
      logic [7:0] idx;
      logic [7:0] bytes [2];
      bytes[0] = b0;
      bytes[1] = b1;
      idx = a[7:0];
      hdr(8'h02, a);
      for (int i = 0; i < nb; i++) begin
         send_in("wr_mode", bytes[i][7:4]);
         send_in("wr_mode", bytes[i][3:0]);
         model[idx] = bytes[i];
         if (inc) idx = idx + 8'd1;
      end
      idle_chk("wr_end");
   endtask

   task automatic rd(input logic [23:0] a, input int nb, input bit inc);
      logic [7:0] idx;
      logic [3:0] e;
      idx = a[7:0];
      for (int i = 0; i < nb; i++) begin
         sbq.push_back(model[idx][7:4]);
         sbq.push_back(model[idx][3:0]);
         if (inc) idx = idx + 8'd1;
      end
      hdr(8'h03, a);
      send_in("dummy_mode", 4'h0);
      tick(1'b0, 4'h0);
      for (int k = 0; k < 2 * nb; k++) begin
         e = (sbq.size() > 0) ? sbq.pop_front() : 4'hx;
         chk("rd_mode", 8'(mode), 8'(SQI_MODE_OUT));
         chk("rd_sio", 8'(sio_out), 8'(e));
         if (k < 2 * nb - 1) tick(1'b0, 4'h0);
      end
      idle_chk("rd_end");
   endtask

   initial begin
      // Reset state
      tick(1'b1, 4'h0);
      tick(1'b0, 4'h3);
      chk("rst_mode", 8'(mode), 8'(SQI_MODE_IN));
      chk("rst_sio", 8'(sio_out), 8'h00);
      rst = 1'b0;
      tick(1'b1, 4'h0);

      // Basic write then read back
      wr(24'h000010, 8'hA5, 8'h3C, 2, 1'b1);
      rd(24'h000010, 2, 1'b1);

      // Upper address bits ignored, wrap from 0xFF to 0x00
      wr(24'hAB00FF, 8'h11, 8'h22, 2, 1'b1);
      rd(24'h0000FF, 2, 1'b1);

      // Abort after a staged hi nibble leaves the byte untouched
      wr(24'h000020, 8'h5A, 8'h00, 1, 1'b1);
      hdr(8'h02, 24'h000020);
      send_in("abort_mode", 4'hB);
      idle_chk("abort");
      rd(24'h000020, 1, 1'b1);

      // Unknown command: never drives, array unchanged, 1-cycle cs gap
      hdr(8'h9F, 24'hFFFFFF);
      send_in("ign_mode", 4'hF);
      send_in("ign_mode", 4'hF);
      idle_chk("ign_end");
      rd(24'h000010, 2, 1'b1);

      // Reset in cycle 11 of a read
      hdr(8'h03, 24'h000010);
      send_in("dummy_mode", 4'h0);
      tick(1'b0, 4'h0);
      tick(1'b0, 4'h0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rrst_mode", 8'(mode), 8'(SQI_MODE_IN));
      chk("rrst_sio", 8'(sio_out), 8'h00);
      rst = 1'b0;
      tick(1'b1, 4'h0);
      rd(24'h000010, 2, 1'b1);

      // Reset on the lo nibble of a write suppresses the commit
      wr(24'h000030, 8'h12, 8'h00, 1, 1'b1);
      hdr(8'h02, 24'h000030);
      send_in("wrst_mode", 4'hF);
      @(negedge clk);
      sio_in = 4'hE;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick(1'b1, 4'h0);
      rd(24'h000030, 1, 1'b1);

`ifdef IDLI_SQI_RESP_MODE_REG_EN
      wr(24'h000006, 8'h66, 8'h00, 1, 1'b1);
      tick(1'b0, 4'h0);
      tick(1'b0, 4'h5);
      chk("rdmr_rst_hi", 8'(sio_out), 8'h04);
      tick(1'b0, 4'h0);
      chk("rdmr_rst_lo", 8'(sio_out), 8'h00);
      idle_chk("rdmr_end");
      hdr(8'h01, 24'h000000);
      idle_chk("wrmr_end");
      wr(24'h000005, 8'h77, 8'h88, 2, 1'b0);
      tick(1'b0, 4'h0);
      tick(1'b0, 4'h5);
      chk("rdmr_hi", 8'(sio_out), 8'h00);
      chk("rdmr_mode", 8'(mode), 8'(SQI_MODE_OUT));
      idle_chk("rdmr2_end");
      rd(24'h000005, 2, 1'b0);
      rd(24'h000006, 1, 1'b0);
`endif

      chk("sb_empty", 8'(sbq.size()), 8'h00);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
